// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Front end of wishbone_master. Consumes the raw byte stream from the UART
// receiver and assembles ASCII-hex command frames:
//
//   SYNC_CHAR, 8 hex digits command, 8 hex digits address, 8 hex digits data
//
// Digits arrive MSB first. There is no terminator. A completed frame is
// committed to the registered outputs and announced with a one-cycle ready
// strobe, but only when master_ready_i allows it; otherwise the frame waits in
// PENDING. Malformed, aborted (resync or timeout) and overrun frames are
// dropped with a one-cycle error strobe. An error strobe never touches the
// output words, and ready/error are never high in the same cycle.
//
// Optional feature (macro UART_CMD_PARSER_LOWERCASE_EN):
//   defined   - 'a'..'f' are also accepted as hex digits 10..15
//   undefined - lowercase letters are non-hex and abort the frame
//
// Parameters:
//   SYNC_CHAR       frame start character
//   TIMEOUT_CYCLES  idle clocks allowed between bytes inside a frame (0 = off)
//   TIMEOUT_WIDTH   width of the inter-byte timeout counter
//
// Ports:
//   clk_i             system clock
//   rst_i             synchronous reset, active high
//   byte_available_i  one-cycle strobe, byte_i valid this cycle
//   byte_i            received character
//   master_ready_i    wishbone_master can accept a command
//   command_o         parsed command word (holds until next commit)
//   address_o         parsed address word (holds until next commit)
//   data_o            parsed data word (holds until next commit)
//   ready_o           one-cycle strobe: outputs hold a new frame
//   error_o           one-cycle strobe: a frame or byte was discarded
//   busy_o            high whenever the parser is not in IDLE
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_CHAR      = 8'h4C,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_available_i,
  input  logic [7:0]  byte_i,
  input  logic        master_ready_i,
  output logic [31:0] command_o,
  output logic [31:0] address_o,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        error_o,
  output logic        busy_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_W  = 3;

  localparam bit                       TMO_EN   = (TIMEOUT_CYCLES != 0);
  // Value the counter holds on the last idle clock before the timeout fires.
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_CMD,
    S_READ_ADDR,
    S_READ_DATA,
    S_PENDING
  } state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         nib_cnt_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
  logic [WORD_W-1:0]        shadow_cmd_q;
  logic [WORD_W-1:0]        shadow_addr_q;
  logic [WORD_W-1:0]        shadow_data_q;
  logic [WORD_W-1:0]        command_q;
  logic [WORD_W-1:0]        address_q;
  logic [WORD_W-1:0]        data_q;
  logic                     ready_q;
  logic                     error_q;

  logic                     hex_valid_c;
  logic [NIB_W-1:0]         hex_nibble_c;

  // ASCII hex digit decode of the incoming byte.
  always_comb begin
    hex_valid_c  = 1'b0;
    hex_nibble_c = '0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      hex_valid_c  = 1'b1;
      hex_nibble_c = byte_i[3:0];
    end else if (byte_i >= 8'h41 && byte_i <= 8'h46) begin
      // 'A' = 8'h41 -> low nibble 1, plus 9 gives 10.
      hex_valid_c  = 1'b1;
      hex_nibble_c = byte_i[3:0] + 4'd9;
    end
`ifdef UART_CMD_PARSER_LOWERCASE_EN
    else if (byte_i >= 8'h61 && byte_i <= 8'h66) begin
      hex_valid_c  = 1'b1;
      hex_nibble_c = byte_i[3:0] + 4'd9;
    end
`else
    // Lowercase letters fall through as non-hex and abort the frame.
`endif
  end

  // Frame FSM, shadow assembly, commit and strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      nib_cnt_q     <= '0;
      tmo_q         <= '0;
      shadow_cmd_q  <= '0;
      shadow_addr_q <= '0;
      shadow_data_q <= '0;
      command_q     <= '0;
      address_q     <= '0;
      data_q        <= '0;
      ready_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (byte_available_i && byte_i == SYNC_CHAR) begin
            state_q       <= S_READ_CMD;
            nib_cnt_q     <= '0;
            shadow_cmd_q  <= '0;
            shadow_addr_q <= '0;
            shadow_data_q <= '0;
          end
        end

        S_READ_CMD, S_READ_ADDR, S_READ_DATA: begin
          if (byte_available_i) begin
            tmo_q <= '0;
            if (hex_valid_c) begin
              nib_cnt_q <= nib_cnt_q + 3'd1;
              if (state_q == S_READ_CMD) begin
                shadow_cmd_q <= {shadow_cmd_q[WORD_W-NIB_W-1:0], hex_nibble_c};
              end else if (state_q == S_READ_ADDR) begin
                shadow_addr_q <= {shadow_addr_q[WORD_W-NIB_W-1:0], hex_nibble_c};
              end else begin
                shadow_data_q <= {shadow_data_q[WORD_W-NIB_W-1:0], hex_nibble_c};
              end

              // Eighth digit of a field: counter wraps and the field is done.
              if (nib_cnt_q == 3'd7) begin
                if (state_q == S_READ_CMD) begin
                  state_q <= S_READ_ADDR;
                end else if (state_q == S_READ_ADDR) begin
                  state_q <= S_READ_DATA;
                end else if (master_ready_i) begin
                  // Commit straight from the shadows plus the final nibble.
                  command_q <= shadow_cmd_q;
                  address_q <= shadow_addr_q;
                  data_q    <= {shadow_data_q[WORD_W-NIB_W-1:0], hex_nibble_c};
                  ready_q   <= 1'b1;
                  state_q   <= S_IDLE;
                end else begin
                  state_q <= S_PENDING;
                end
              end
            end else if (byte_i == SYNC_CHAR) begin
              // Resync: abandon the partial frame and start a new one.
              error_q       <= 1'b1;
              state_q       <= S_READ_CMD;
              nib_cnt_q     <= '0;
              shadow_cmd_q  <= '0;
              shadow_addr_q <= '0;
              shadow_data_q <= '0;
            end else begin
              error_q   <= 1'b1;
              state_q   <= S_IDLE;
              nib_cnt_q <= '0;
            end
          end else if (TMO_EN && tmo_q == TMO_LAST) begin
            error_q   <= 1'b1;
            state_q   <= S_IDLE;
            nib_cnt_q <= '0;
            tmo_q     <= '0;
          end else begin
            tmo_q <= tmo_q + TIMEOUT_WIDTH'(1);
          end
        end

        S_PENDING: begin
          tmo_q <= '0;
          // A byte arriving while a frame waits is an overrun; the byte is
          // dropped and the commit deferred so ready/error never coincide.
          if (byte_available_i) begin
            error_q <= 1'b1;
          end else if (master_ready_i) begin
            command_q <= shadow_cmd_q;
            address_q <= shadow_addr_q;
            data_q    <= shadow_data_q;
            ready_q   <= 1'b1;
            state_q   <= S_IDLE;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          nib_cnt_q <= '0;
          tmo_q     <= '0;
        end
      endcase
    end
  end

  assign command_o = command_q;
  assign address_o = address_q;
  assign data_o    = data_q;
  assign ready_o   = ready_q;
  assign error_o   = error_q;
  // Decoded straight from the state register.
  assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Directed bench for uart_cmd_parser. Bytes are sent one every 6 clocks.
// Inputs change and outputs are sampled 1 ns after the rising edge, so a value
// observed right after send_byte() reflects the edge that captured the byte.
// The DUT is built with TIMEOUT_CYCLES = 50.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_available = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        master_ready = 1'b1;
  logic [31:0] command_o;
  logic [31:0] address_o;
  logic [31:0] data_o;
  logic        ready_o;
  logic        error_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  int ready_cnt = 0;
  int error_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .SYNC_CHAR      (8'h4C),
    .TIMEOUT_CYCLES (50),
    .TIMEOUT_WIDTH  (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .byte_available_i (byte_available),
    .byte_i           (rx_byte),
    .master_ready_i   (master_ready),
    .command_o        (command_o),
    .address_o        (address_o),
    .data_o           (data_o),
    .ready_o          (ready_o),
    .error_o          (error_o),
    .busy_o           (busy_o)
  );

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (ready_o === 1'b1) ready_cnt++;
    if (error_o === 1'b1) error_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_available = 1'b1;
    rx_byte        = b;
    tick();
    byte_available = 1'b0;
    rx_byte        = 8'h00;
  endtask

  // Sends a string with 6 clocks per byte; returns right after the last byte.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(8'(s[i]));
      if (i < s.len() - 1) repeat (5) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (command_o !== 32'h0) begin errors++; $display("FAIL reset_command: got %h expected %h", command_o, 32'h0); end
    checks++; if (address_o !== 32'h0) begin errors++; $display("FAIL reset_address: got %h expected %h", address_o, 32'h0); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", data_o, 32'h0); end
    checks++; if ({ready_o, error_o, busy_o} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected %b", {ready_o, error_o, busy_o}, 3'b000); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int r0, e0;
    master_ready = 1'b1;
    r0 = ready_cnt; e0 = error_cnt;
    send_str("L0000000100000000DEADBEE");
    repeat (5) tick();
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL basic_no_partial: got %h expected %h", data_o, 32'h0); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected %b", busy_o, 1'b1); end
    send_byte(8'h46);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected %b", ready_o, 1'b1); end
    checks++; if (command_o !== 32'h00000001) begin errors++; $display("FAIL basic_command: got %h expected %h", command_o, 32'h00000001); end
    checks++; if (address_o !== 32'h00000000) begin errors++; $display("FAIL basic_address: got %h expected %h", address_o, 32'h00000000); end
    checks++; if (data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data: got %h expected %h", data_o, 32'hDEADBEEF); end
    tick();
    checks++; if ({ready_o, busy_o} !== 2'b00) begin errors++; $display("FAIL basic_after: got %b expected %b", {ready_o, busy_o}, 2'b00); end
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL basic_ready_count: got %0d expected %0d", ready_cnt - r0, 1); end
    checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL basic_error_count: got %0d expected %0d", error_cnt - e0, 0); end
    repeat (5) tick();
  endtask

  task automatic test_backpressure();
    int r0, e0;
    master_ready = 1'b0;
    r0 = ready_cnt; e0 = error_cnt;
    send_str("L000000A500001234CAFEF00D");
    checks++; if ({ready_o, busy_o} !== 2'b01) begin errors++; $display("FAIL bp_pending: got %b expected %b", {ready_o, busy_o}, 2'b01); end
    checks++; if (command_o !== 32'h00000001) begin errors++; $display("FAIL bp_hold_cmd: got %h expected %h", command_o, 32'h00000001); end
    repeat (5) tick();
    send_byte(8'h35);
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL bp_overrun_error: got %b expected %b", error_o, 1'b1); end
    checks++; if (data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_overrun_hold: got %h expected %h", data_o, 32'hDEADBEEF); end
    // Wait beyond the timeout: PENDING must not time out.
    repeat (53) tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_no_timeout: got %b expected %b", busy_o, 1'b1); end
    master_ready = 1'b1;
    tick();
    checks++; if ({ready_o, error_o} !== 2'b10) begin errors++; $display("FAIL bp_ready: got %b expected %b", {ready_o, error_o}, 2'b10); end
    checks++; if (command_o !== 32'h000000A5) begin errors++; $display("FAIL bp_command: got %h expected %h", command_o, 32'h000000A5); end
    checks++; if (address_o !== 32'h00001234) begin errors++; $display("FAIL bp_address: got %h expected %h", address_o, 32'h00001234); end
    checks++; if (data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_data: got %h expected %h", data_o, 32'hCAFEF00D); end
    tick();
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL bp_ready_count: got %0d expected %0d", ready_cnt - r0, 1); end
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL bp_error_count: got %0d expected %0d", error_cnt - e0, 1); end
    repeat (5) tick();
  endtask

  task automatic test_bad_digit();
    int r0, e0;
    master_ready = 1'b1;
    r0 = ready_cnt; e0 = error_cnt;
    send_str("L0000G");
    checks++; if ({error_o, busy_o} !== 2'b10) begin errors++; $display("FAIL bad_error_idle: got %b expected %b", {error_o, busy_o}, 2'b10); end
    checks++; if (command_o !== 32'h000000A5) begin errors++; $display("FAIL bad_hold_cmd: got %h expected %h", command_o, 32'h000000A5); end
    checks++; if (data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL bad_hold_data: got %h expected %h", data_o, 32'hCAFEF00D); end
    repeat (6) tick();
    send_str("L0000ABCD0000001076543210");
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bad_next_ready: got %b expected %b", ready_o, 1'b1); end
    checks++; if (command_o !== 32'h0000ABCD) begin errors++; $display("FAIL bad_next_command: got %h expected %h", command_o, 32'h0000ABCD); end
    checks++; if (address_o !== 32'h00000010) begin errors++; $display("FAIL bad_next_address: got %h expected %h", address_o, 32'h00000010); end
    checks++; if (data_o !== 32'h76543210) begin errors++; $display("FAIL bad_next_data: got %h expected %h", data_o, 32'h76543210); end
    tick();
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL bad_error_count: got %0d expected %0d", error_cnt - e0, 1); end
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL bad_ready_count: got %0d expected %0d", ready_cnt - r0, 1); end
    repeat (5) tick();
  endtask

  task automatic test_resync();
    int r0, e0;
    master_ready = 1'b1;
    r0 = ready_cnt; e0 = error_cnt;
    send_str("L0000");
    repeat (5) tick();
    send_byte(8'h4C);
    checks++; if ({error_o, busy_o} !== 2'b11) begin errors++; $display("FAIL resync_error_busy: got %b expected %b", {error_o, busy_o}, 2'b11); end
    repeat (5) tick();
    send_str("000000020000010012345678");
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL resync_ready: got %b expected %b", ready_o, 1'b1); end
    checks++; if (command_o !== 32'h00000002) begin errors++; $display("FAIL resync_command: got %h expected %h", command_o, 32'h00000002); end
    checks++; if (address_o !== 32'h00000100) begin errors++; $display("FAIL resync_address: got %h expected %h", address_o, 32'h00000100); end
    checks++; if (data_o !== 32'h12345678) begin errors++; $display("FAIL resync_data: got %h expected %h", data_o, 32'h12345678); end
    tick();
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL resync_error_count: got %0d expected %0d", error_cnt - e0, 1); end
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL resync_ready_count: got %0d expected %0d", ready_cnt - r0, 1); end
    repeat (5) tick();
  endtask

  task automatic test_timeout();
    int r0, e0;
    r0 = ready_cnt; e0 = error_cnt;
    send_str("L0000");
    // Error must appear 50 edges after the edge that captured the last byte.
    repeat (49) tick();
    checks++; if ({error_o, busy_o} !== 2'b01) begin errors++; $display("FAIL tmo_early: got %b expected %b", {error_o, busy_o}, 2'b01); end
    tick();
    checks++; if ({error_o, busy_o} !== 2'b10) begin errors++; $display("FAIL tmo_fire: got %b expected %b", {error_o, busy_o}, 2'b10); end
    checks++; if (data_o !== 32'h12345678) begin errors++; $display("FAIL tmo_hold_data: got %h expected %h", data_o, 32'h12345678); end
    tick();
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL tmo_error_count: got %0d expected %0d", error_cnt - e0, 1); end
    checks++; if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL tmo_ready_count: got %0d expected %0d", ready_cnt - r0, 0); end
    repeat (5) tick();
  endtask

  task automatic test_lowercase();
    int r0, e0;
    master_ready = 1'b1;
    r0 = ready_cnt; e0 = error_cnt;
`ifdef UART_CMD_PARSER_LOWERCASE_EN
    send_str("L0000000300000004deadbeef");
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL lc_ready: got %b expected %b", ready_o, 1'b1); end
    checks++; if (command_o !== 32'h00000003) begin errors++; $display("FAIL lc_command: got %h expected %h", command_o, 32'h00000003); end
    checks++; if (address_o !== 32'h00000004) begin errors++; $display("FAIL lc_address: got %h expected %h", address_o, 32'h00000004); end
    checks++; if (data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lc_data: got %h expected %h", data_o, 32'hDEADBEEF); end
    tick();
    checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL lc_error_count: got %0d expected %0d", error_cnt - e0, 0); end
    checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL lc_ready_count: got %0d expected %0d", ready_cnt - r0, 1); end
`else
    send_str("L0000000300000004");
    repeat (5) tick();
    send_byte(8'h64);
    checks++; if ({error_o, busy_o} !== 2'b10) begin errors++; $display("FAIL lc_abort: got %b expected %b", {error_o, busy_o}, 2'b10); end
    checks++; if (data_o !== 32'h12345678) begin errors++; $display("FAIL lc_hold_data: got %h expected %h", data_o, 32'h12345678); end
    repeat (5) tick();
    // Remaining digits land in IDLE and must be ignored silently.
    send_str("eadbeef");
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL lc_idle: got %b expected %b", busy_o, 1'b0); end
    checks++; if (error_cnt - e0 !== 1) begin errors++; $display("FAIL lc_error_count: got %0d expected %0d", error_cnt - e0, 1); end
    checks++; if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL lc_ready_count: got %0d expected %0d", ready_cnt - r0, 0); end
`endif
    repeat (5) tick();
  endtask

  task automatic test_reset_midframe();
    int r0, e0;
    master_ready = 1'b1;
    send_str("L000000050000");
    repeat (2) tick();
    r0 = ready_cnt; e0 = error_cnt;
    rst = 1'b1;
    tick();
    checks++; if (command_o !== 32'h0) begin errors++; $display("FAIL rstmid_command: got %h expected %h", command_o, 32'h0); end
    checks++; if (address_o !== 32'h0) begin errors++; $display("FAIL rstmid_address: got %h expected %h", address_o, 32'h0); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected %h", data_o, 32'h0); end
    checks++; if ({ready_o, error_o, busy_o} !== 3'b000) begin errors++; $display("FAIL rstmid_strobes: got %b expected %b", {ready_o, error_o, busy_o}, 3'b000); end
    rst = 1'b0;
    repeat (60) tick();
    checks++; if (error_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_error_count: got %0d expected %0d", error_cnt - e0, 0); end
    checks++; if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL rstmid_ready_count: got %0d expected %0d", ready_cnt - r0, 0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b expected %b", busy_o, 1'b0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_digit();
    test_resync();
    test_timeout();
    test_lowercase();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
